// File: rtl/apb_bridge_ctrl_if.sv
// apb_bridge_ctrl_if -- AHB-slave / APB-master signal bundle for apb_bridge_ctrl.
//   AHB side : Hwrite, Htrans[1:0], Haddr[31:0], Hwdata[31:0], Hreadyin  (to bridge)
//              Hreadyout, Hresp[1:0], Hrdata[31:0]                       (from bridge)
//   APB side : Prdata[31:0]                                               (to bridge)
//              Pselx[3:0], Penable, Pwrite, Paddr[31:0], Pwdata[31:0]     (from bridge)
// Modports: slave = the bridge's view, master = the surrounding system's view.
interface apb_bridge_ctrl_if;
  logic        Hwrite;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic [31:0] Prdata;

  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  modport slave (
    input  Hwrite, Htrans, Haddr, Hwdata, Hreadyin, Prdata,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
  );

  modport master (
    output Hwrite, Htrans, Haddr, Hwdata, Hreadyin, Prdata,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl -- AHB-to-APB bridge controller, four APB slaves.
// Ports:
//   clock  : single clock, all state on posedge
//   Hreset : synchronous active-high reset
//   bus    : apb_bridge_ctrl_if.slave (AHB transfer in, APB access out)
// Slave decode on Haddr[31:26]: 6'h20..6'h23 -> Pselx 0001/0010/0100/1000.
// Read: SETUP, ACCESS. Write: WWAIT (data phase capture), SETUP, ACCESS.
// A new address phase is accepted in IDLE or ACCESS, so back-to-back
// transfers run without an idle cycle.
// Optional macro APB_BRIDGE_ERR_RESP_EN: unmapped valid transfers get a
// two-cycle ERROR response (ERR1/ERR2); otherwise they are ignored.
module apb_bridge_ctrl (
  input  logic               clock,
  input  logic               Hreset,
  apb_bridge_ctrl_if.slave   bus
);

`ifdef APB_BRIDGE_ERR_RESP_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS
  } state_t;
`endif

  state_t      state, next_state;

  logic [31:0] paddr_q;
  logic        pwrite_q;
  logic [31:0] pwdata_q;
  logic [3:0]  sel_q;

  logic        valid;
  logic [3:0]  sel_dec;
  logic        mapped;
  logic        addr_phase_ok;
  logic        accept;

  // NONSEQ (10) and SEQ (11) are real transfers; IDLE/BUSY are ignored.
  always_comb begin
    valid = 1'b0;
    case (bus.Htrans)
      2'b10, 2'b11: valid = bus.Hreadyin;
      default:      valid = 1'b0;
    endcase
  end

  always_comb begin
    sel_dec = '0;
    case (bus.Haddr[31:26])
      6'h20:   sel_dec = 4'b0001;
      6'h21:   sel_dec = 4'b0010;
      6'h22:   sel_dec = 4'b0100;
      6'h23:   sel_dec = 4'b1000;
      default: sel_dec = '0;
    endcase
  end

  assign mapped        = |sel_dec;
  assign addr_phase_ok = (state == ST_IDLE) || (state == ST_ACCESS);
  assign accept        = addr_phase_ok && valid && mapped;

  always_ff @(posedge clock) begin
    if (Hreset) begin
      state    <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      sel_q    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
        sel_q    <= sel_dec;
      end
      if (state == ST_WWAIT)
        pwdata_q <= bus.Hwdata;
    end
  end

  always_comb begin
    next_state    = state;
    bus.Pselx     = '0;
    bus.Penable   = 1'b0;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = '0;
    bus.Paddr     = paddr_q;
    bus.Pwrite    = pwrite_q;
    bus.Pwdata    = pwdata_q;

    // IDLE and ACCESS share the address-phase decision.
    if (addr_phase_ok) begin
      if (accept)
        next_state = bus.Hwrite ? ST_WWAIT : ST_SETUP;
`ifdef APB_BRIDGE_ERR_RESP_EN
      else if (valid)
        next_state = ST_ERR1;
`endif
      else
        next_state = ST_IDLE;
    end

    case (state)
      ST_IDLE: begin
        bus.Hreadyout = 1'b1;
      end
      ST_WWAIT: begin
        bus.Hreadyout = 1'b0;
        next_state    = ST_SETUP;
      end
      ST_SETUP: begin
        bus.Pselx     = sel_q;
        bus.Hreadyout = 1'b0;
        next_state    = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.Pselx     = sel_q;
        bus.Penable   = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hrdata    = pwrite_q ? '0 : bus.Prdata;
      end
`ifdef APB_BRIDGE_ERR_RESP_EN
      ST_ERR1: begin
        bus.Hresp     = 2'b01;
        bus.Hreadyout = 1'b0;
        next_state    = ST_ERR2;
      end
      ST_ERR2: begin
        bus.Hresp     = 2'b01;
        bus.Hreadyout = 1'b1;
        next_state    = ST_IDLE;
      end
`endif
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
module tb_apb_bridge_ctrl;
  logic clock;
  logic Hreset;
  int unsigned total;
  int unsigned bad;

  apb_bridge_ctrl_if bus ();

  apb_bridge_ctrl dut (
    .clock  (clock),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [31:0] addr);
    bus.Htrans = trans;
    bus.Hwrite = wr;
    bus.Haddr  = addr;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".psel"},  {28'd0, bus.Pselx}, 32'd0);
    check({tag, ".pen"},   {31'd0, bus.Penable}, 32'd0);
    check({tag, ".pwr"},   {31'd0, bus.Pwrite}, 32'd0);
    check({tag, ".paddr"}, bus.Paddr, 32'd0);
    check({tag, ".pwd"},   bus.Pwdata, 32'd0);
    check({tag, ".hrdy"},  {31'd0, bus.Hreadyout}, 32'd1);
    check({tag, ".hresp"}, {30'd0, bus.Hresp}, 32'd0);
    check({tag, ".hrd"},   bus.Hrdata, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Hreset       = 1'b1;
    bus.Hreadyin = 1'b1;
    bus.Hwdata   = '0;
    bus.Prdata   = '0;
    drive(2'b00, 1'b0, 32'h0);

    tick();
    tick();
    check_reset_vals("rst");
    Hreset = 1'b0;

    // Read 0x8000_0010
    bus.Prdata = 32'hCAFE_0001;
    drive(2'b10, 1'b0, 32'h8000_0010);
    check("rd.idle.hrdy", {31'd0, bus.Hreadyout}, 32'd1);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    check("rd.setup.psel", {28'd0, bus.Pselx}, 32'h1);
    check("rd.setup.pen",  {31'd0, bus.Penable}, 32'd0);
    check("rd.setup.hrdy", {31'd0, bus.Hreadyout}, 32'd0);
    check("rd.setup.hrd",  bus.Hrdata, 32'd0);
    check("rd.setup.paddr", bus.Paddr, 32'h8000_0010);
    tick();
    check("rd.acc.psel", {28'd0, bus.Pselx}, 32'h1);
    check("rd.acc.pen",  {31'd0, bus.Penable}, 32'd1);
    check("rd.acc.hrdy", {31'd0, bus.Hreadyout}, 32'd1);
    check("rd.acc.hrd",  bus.Hrdata, 32'hCAFE_0001);
    tick();
    check("rd.idle2.psel", {28'd0, bus.Pselx}, 32'h0);
    check("rd.idle2.hrd",  bus.Hrdata, 32'd0);

    // Write 0x8C00_0004; a held address phase during stall must not be captured
    drive(2'b10, 1'b1, 32'h8C00_0004);
    tick();
    bus.Hwdata = 32'h1234_5678;
    drive(2'b10, 1'b0, 32'h8000_0020);
    check("wr.wwait.hrdy", {31'd0, bus.Hreadyout}, 32'd0);
    check("wr.wwait.psel", {28'd0, bus.Pselx}, 32'h0);
    check("wr.wwait.pen",  {31'd0, bus.Penable}, 32'd0);
    tick();
    bus.Hwdata = 32'hFFFF_0000;
    check("wr.setup.psel", {28'd0, bus.Pselx}, 32'h8);
    check("wr.setup.pen",  {31'd0, bus.Penable}, 32'd0);
    check("wr.setup.hrdy", {31'd0, bus.Hreadyout}, 32'd0);
    check("wr.setup.pwd",  bus.Pwdata, 32'h1234_5678);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    check("wr.acc.psel",  {28'd0, bus.Pselx}, 32'h8);
    check("wr.acc.pen",   {31'd0, bus.Penable}, 32'd1);
    check("wr.acc.pwr",   {31'd0, bus.Pwrite}, 32'd1);
    check("wr.acc.pwd",   bus.Pwdata, 32'h1234_5678);
    check("wr.acc.paddr", bus.Paddr, 32'h8C00_0004);
    check("wr.acc.hrd",   bus.Hrdata, 32'd0);
    tick();
    check("wr.idle.psel", {28'd0, bus.Pselx}, 32'h0);
    check("wr.idle.pwd",  bus.Pwdata, 32'h1234_5678);

    // Back-to-back: read 0x8400_0000 then write 0x8800_0008 in its ACCESS
    bus.Prdata = 32'h0BAD_0002;
    drive(2'b10, 1'b0, 32'h8400_0000);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    check("b2b.setup.psel", {28'd0, bus.Pselx}, 32'h2);
    tick();
    drive(2'b10, 1'b1, 32'h8800_0008);
    check("b2b.acc.psel", {28'd0, bus.Pselx}, 32'h2);
    check("b2b.acc.hrd",  bus.Hrdata, 32'h0BAD_0002);
    check("b2b.acc.pwr",  {31'd0, bus.Pwrite}, 32'd0);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    bus.Hwdata = 32'hA5A5_0003;
    check("b2b.wwait.psel", {28'd0, bus.Pselx}, 32'h0);
    check("b2b.wwait.hrdy", {31'd0, bus.Hreadyout}, 32'd0);
    check("b2b.wwait.pen",  {31'd0, bus.Penable}, 32'd0);
    tick();
    check("b2b.setup2.psel", {28'd0, bus.Pselx}, 32'h4);
    tick();
    check("b2b.acc2.pen",   {31'd0, bus.Penable}, 32'd1);
    check("b2b.acc2.pwd",   bus.Pwdata, 32'hA5A5_0003);
    check("b2b.acc2.paddr", bus.Paddr, 32'h8800_0008);
    tick();

    // BUSY and Hreadyin=0 with a mapped address are ignored
    drive(2'b01, 1'b0, 32'h8000_0000);
    tick();
    check("busy.psel", {28'd0, bus.Pselx}, 32'h0);
    check("busy.hrdy", {31'd0, bus.Hreadyout}, 32'd1);
    tick();
    check("busy2.psel", {28'd0, bus.Pselx}, 32'h0);
    check("busy.paddr", bus.Paddr, 32'h8800_0008);
    drive(2'b10, 1'b0, 32'h8000_0000);
    bus.Hreadyin = 1'b0;
    tick();
    check("nordy.psel",  {28'd0, bus.Pselx}, 32'h0);
    check("nordy.hrdy",  {31'd0, bus.Hreadyout}, 32'd1);
    check("nordy.paddr", bus.Paddr, 32'h8800_0008);
    bus.Hreadyin = 1'b1;
    drive(2'b00, 1'b0, 32'h0);
    tick();

    // Unmapped write 0x9000_0000
    drive(2'b10, 1'b1, 32'h9000_0000);
    tick();
`ifdef APB_BRIDGE_ERR_RESP_EN
    drive(2'b00, 1'b0, 32'h0);
    check("err1.hresp", {30'd0, bus.Hresp}, 32'd1);
    check("err1.hrdy",  {31'd0, bus.Hreadyout}, 32'd0);
    check("err1.psel",  {28'd0, bus.Pselx}, 32'h0);
    tick();
    drive(2'b10, 1'b0, 32'h8000_0000);
    check("err2.hresp", {30'd0, bus.Hresp}, 32'd1);
    check("err2.hrdy",  {31'd0, bus.Hreadyout}, 32'd1);
    check("err2.psel",  {28'd0, bus.Pselx}, 32'h0);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    check("err.idle.hresp", {30'd0, bus.Hresp}, 32'd0);
    check("err.idle.hrdy",  {31'd0, bus.Hreadyout}, 32'd1);
    check("err.idle.psel",  {28'd0, bus.Pselx}, 32'h0);
    tick();
`else
    drive(2'b00, 1'b0, 32'h0);
    check("unm.hresp", {30'd0, bus.Hresp}, 32'd0);
    check("unm.hrdy",  {31'd0, bus.Hreadyout}, 32'd1);
    check("unm.psel",  {28'd0, bus.Pselx}, 32'h0);
    check("unm.paddr", bus.Paddr, 32'h8800_0008);
    tick();
    check("unm2.hrdy", {31'd0, bus.Hreadyout}, 32'd1);
    check("unm2.psel", {28'd0, bus.Pselx}, 32'h0);
`endif
    check("unm.pen", {31'd0, bus.Penable}, 32'd0);

    // Reset pulse during SETUP of a write, with a valid transfer alongside
    drive(2'b10, 1'b1, 32'h8000_0040);
    tick();
    drive(2'b00, 1'b0, 32'h0);
    bus.Hwdata = 32'hDEAD_BEEF;
    tick();
    check("rstmid.setup.psel", {28'd0, bus.Pselx}, 32'h1);
    Hreset = 1'b1;
    drive(2'b10, 1'b0, 32'h8400_0000);
    tick();
    check_reset_vals("rstmid");
    Hreset = 1'b0;
    drive(2'b00, 1'b0, 32'h0);
    tick();
    check("rstmid.after.pen",  {31'd0, bus.Penable}, 32'd0);
    check("rstmid.after.psel", {28'd0, bus.Pselx}, 32'h0);
    check("rstmid.after.hrdy", {31'd0, bus.Hreadyout}, 32'd1);
    tick();
    check("rstmid.after2.pen", {31'd0, bus.Penable}, 32'd0);

    // Reset dominates a valid transfer presented in IDLE
    Hreset = 1'b1;
    drive(2'b10, 1'b0, 32'h8000_0000);
    tick();
    Hreset = 1'b0;
    drive(2'b00, 1'b0, 32'h0);
    tick();
    check("rstdom.psel",  {28'd0, bus.Pselx}, 32'h0);
    check("rstdom.hrdy",  {31'd0, bus.Hreadyout}, 32'd1);
    check("rstdom.paddr", bus.Paddr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_bridge_ctrl.md
APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock, all state updates on posedge.
REQ-002 SHALL have port Hreset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have AHB inputs:
- Hwrite, 1 bit: transfer direction.
- Htrans, 2 bits: transfer type.
- Haddr, 32 bits: transfer address.
- Hwdata, 32 bits: write data.
- Hreadyin, 1 bit: bus-ready qualifier.
REQ-004 SHALL have input Prdata, 32 bits: APB read data.
REQ-005 SHALL have APB outputs:
- Pselx, 4 bits: one-hot slave select.
- Penable, 1 bit: APB access phase.
- Pwrite, 1 bit: APB direction.
- Paddr, 32 bits: APB address.
- Pwdata, 32 bits: APB write data.
REQ-006 SHALL have AHB outputs:
- Hreadyout, 1 bit: transfer-done / stall.
- Hresp, 2 bits: response, 00 = OKAY, 01 = ERROR.
- Hrdata, 32 bits: read data.

Function
REQ-007 valid = Hreadyin & Htrans[1] (NONSEQ/SEQ); IDLE and BUSY transfers SHALL be ignored; Hsize/Hburst not used.
REQ-008 Decode SHALL map Haddr[31:26] to slaves:
- 6'h20 -> Pselx = 0001
- 6'h21 -> 0010
- 6'h22 -> 0100
- 6'h23 -> 1000
- anything else -> unmapped.
REQ-009 FSM states SHALL be ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, plus ST_ERR1, ST_ERR2 (macro only).
REQ-010 Address-phase acceptance SHALL occur only in ST_IDLE or ST_ACCESS; on a valid mapped transfer, Haddr, Hwrite and the decode SHALL be latched.
- Hwrite = 1 -> next state ST_WWAIT.
- Hwrite = 0 -> next state ST_SETUP.
- No accept -> next state ST_IDLE.
REQ-011 ST_WWAIT: Hreadyout = 0; Hwdata latched into Pwdata at end of cycle; next state ST_SETUP.
REQ-012 ST_SETUP: Pselx = latched decode, Penable = 0, Hreadyout = 0; next state ST_ACCESS.
REQ-013 ST_ACCESS: Pselx held, Penable = 1, Hreadyout = 1; APB transfer completes this cycle.
REQ-014 In ST_ACCESS of a read, Hrdata SHALL equal Prdata combinationally; Hrdata SHALL be 0 in all other cycles.
REQ-015 Pselx and Penable SHALL be 0 outside ST_SETUP/ST_ACCESS.
REQ-016 Paddr, Pwrite and Pwdata SHALL hold their values until the next capture.
REQ-017 Hreadyout SHALL be 1 in ST_IDLE and ST_ACCESS, 0 in ST_WWAIT and ST_SETUP.
REQ-018 Latency from the address-phase cycle SHALL be:
- read: 2 cycles to completion (SETUP, ACCESS).
- write: 3 cycles (WWAIT, SETUP, ACCESS).
REQ-019 Back-to-back transfers accepted in ST_ACCESS SHALL start without an intervening ST_IDLE cycle.
REQ-020 Address phases presented while Hreadyout = 0 SHALL NOT be captured; the master holds them.
REQ-021 With the macro undefined, Hresp SHALL be constant 00 and unmapped valid transfers SHALL be ignored: state stays or returns to ST_IDLE, Hreadyout = 1.

Reset
REQ-022 Hreset = 1 at posedge SHALL force:
- state ST_IDLE.
- Pselx = 0, Penable = 0, Pwrite = 0.
- Paddr = 0, Pwdata = 0.
- Hreadyout = 1, Hresp = 00, Hrdata = 0.
REQ-023 Reset asserted mid-transfer (any state) SHALL abort it with no APB access phase issued; reset SHALL dominate any simultaneous valid transfer.

Configuration
REQ-024 Macro APB_BRIDGE_ERR_RESP_EN defined: an unmapped valid transfer accepted in ST_IDLE/ST_ACCESS SHALL run a two-cycle error response with no APB select.
- ST_ERR1: Hresp = 01, Hreadyout = 0.
- ST_ERR2: Hresp = 01, Hreadyout = 1.
- Then ST_IDLE; any address phase during ST_ERR2 is ignored.
REQ-025 Macro undefined: ST_ERR1/ST_ERR2 SHALL not exist and REQ-021 applies.

Verification
REQ-026 Read 0x8000_0010, Prdata = 0xCAFE_0001:
- cycle+1: Pselx = 0001, Penable = 0, Hreadyout = 0.
- cycle+2: Penable = 1, Hreadyout = 1, Hrdata = 0xCAFE_0001.
REQ-027 Write 0x8C00_0004, data 0x1234_5678:
- WWAIT, SETUP, then ACCESS.
- In ACCESS: Pselx = 1000, Pwrite = 1, Pwdata = 0x1234_5678, Paddr = 0x8C00_0004.
REQ-028 Read 0x8400_0000 followed in its ACCESS cycle by write 0x8800_0008: next cycle ST_WWAIT directly, Pselx = 0 in WWAIT, then Pselx = 0100.
REQ-029 Htrans = 01 (BUSY) or Hreadyin = 0 with a mapped address: no state change, Pselx stays 0, Hreadyout = 1.
REQ-030 Write to 0x9000_0000:
- Macro defined: Hresp = 01 for 2 cycles, Hreadyout 0 then 1, Pselx = 0.
- Macro undefined: ignored, Hresp = 00.
REQ-031 Hreset pulsed for one cycle during ST_SETUP of a write: next cycle all outputs at reset values, and no Penable = 1 cycle follows.
